tero_scan_ctrl: RTL
===================

TERO_SCAN_CTRL -- requirements
Module: tero_scan_ctrl

Interface
REQ-001 Parameter N_TERO_BITS, default 5, meaning TERO index width; N_TERO = 2**N_TERO_BITS, always even.
REQ-002 Parameter CHALLENGE_BITS, default 4, meaning challenge width; the challenge value is used modulo N_TERO.
REQ-003 Parameter CNT_BITS, default 16, meaning oscillation counter width.
REQ-004 Parameter SETTLE_CYCLES, default 16, meaning cycles per TERO from enable to the start of counting; minimum 1.
REQ-005 Parameter WINDOW_CYCLES, default 1024, meaning counting window length in cycles; minimum 1.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 start  input  1  scan request; sampled only in IDLE.
REQ-009 challenge_in  input  CHALLENGE_BITS  pairing offset; latched when start is accepted.
REQ-010 tero_pulse  input  1  one-cycle pulse per oscillation of the selected TERO, already synchronised to clk.
REQ-011 tero_sel  output  N_TERO_BITS  index of the TERO being measured.
REQ-012 tero_en  output  1  enable for the selected TERO.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the response is complete.
REQ-015 response  output  N_TERO/2  one bit per pair; held stable from done until the next accepted start.

Function
REQ-016 The FSM SHALL have the states IDLE, SETTLE, MEASURE, STORE and DONE.
REQ-017 IDLE: start=1 latches challenge_in, sets pair index k=0 and phase=A, clears response, then moves to SETTLE.
REQ-018 In phase A, tero_sel = (2k + challenge) mod N_TERO; in phase B, tero_sel = (2k + 1 + challenge) mod N_TERO; the modulo arithmetic wraps naturally in N_TERO_BITS.
REQ-019 SETTLE lasts exactly SETTLE_CYCLES cycles with tero_en=1, the counter cleared, and pulses ignored; it then moves to MEASURE.
REQ-020 MEASURE lasts exactly WINDOW_CYCLES cycles with tero_en=1; each cycle with tero_pulse=1 increments the counter; the counter saturates at 2**CNT_BITS-1 and never wraps.
REQ-021 STORE lasts 1 cycle with tero_en=0 and counting stopped.
REQ-022 STORE, phase A: cnt_a <= count; phase <= B; next state SETTLE.
REQ-023 STORE, phase B: response[k] <= (cnt_a > count); a tie gives 0.
REQ-024 After a phase-B STORE: if k = N_TERO/2-1, go to DONE; otherwise k <= k+1, phase <= A, and go to SETTLE.
REQ-025 DONE lasts 1 cycle with done=1 and tero_en=0, then goes to IDLE.
REQ-026 Each TERO SHALL take SETTLE_CYCLES+WINDOW_CYCLES+1 cycles.
REQ-027 With start accepted at cycle 0, done=1 SHALL occur at cycle N_TERO*(SETTLE_CYCLES+WINDOW_CYCLES+1)+1.
REQ-028 start while busy=1 SHALL be ignored and SHALL NOT be queued; challenge_in changes while busy SHALL have no effect.
REQ-029 start=1 in the same cycle as the DONE state SHALL be ignored; a new scan is accepted only from IDLE.
REQ-030 tero_pulse outside MEASURE SHALL NOT affect any count.

Reset
REQ-031 While reset=0 at a clock edge, the block SHALL clear the FSM to IDLE, clear k, phase, counter, cnt_a and the latched challenge, and drive tero_sel=0, tero_en=0, busy=0, done=0, response=0.
REQ-032 A reset asserted mid-scan SHALL abort the scan the next edge with no done pulse, and the partial response is discarded.

Configuration
REQ-033 With macro TERO_SCAN_DBG_EN defined, the block SHALL add outputs cnt_dbg (CNT_BITS) and cnt_dbg_valid (1).
REQ-034 With TERO_SCAN_DBG_EN defined, cnt_dbg_valid SHALL pulse for one cycle in every STORE cycle, and cnt_dbg SHALL equal the count for the current tero_sel; both reset to 0.
REQ-035 Without TERO_SCAN_DBG_EN, those ports and their logic SHALL be absent and all other behaviour is identical.

Structure
REQ-036 Package tero_pkg SHALL hold the FSM state enum (IDLE, SETTLE, MEASURE, STORE, DONE) and the default parameter constants.
REQ-037 The block SHALL contain one sub-module, tero_edge_counter: a saturating counter with clear and count-enable, CNT_BITS wide.

Verification (N_TERO_BITS=2, SETTLE=4, WINDOW=16, CNT_BITS=4)
REQ-038 Scan 1: challenge=0; pulse counts per TERO 5, 3, 2, 9. Required: tero_sel sequence 0,1,2,3; response=2'b01; done at cycle 85.
REQ-039 Scan 2: challenge=3; pulse counts for TERO 3, 0, 1, 2 are 7, 7, 1, 4. Required: sel sequence 3,0,1,2 (wrap); response=2'b00 (tie bit 0).
REQ-040 Scan 3: pulse on every MEASURE cycle for 16 cycles. Required: count saturates at 15; equal pairs give bit 0.
REQ-041 Scan 4: start pulses during busy, and start held high through DONE. Required: exactly one done per accepted scan, and a second scan starts only after IDLE.
REQ-042 Scan 5: reset=0 at cycle 30 of a scan. Required: next edge tero_en=0, busy=0, response=0, no done; a later start scans normally.
REQ-043 Scan 6: with TERO_SCAN_DBG_EN, scan 1 stimulus. Required: four cnt_dbg_valid pulses with values 5, 3, 2, 9.

Source files
------------

// File: rtl/tero_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tero_pkg
// Description : Shared FSM state encoding and default parameter values for
//               the TERO scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tero_pkg;

    // Default configuration values
    localparam int c_DEF_N_TERO_BITS    = 5;
    localparam int c_DEF_CHALLENGE_BITS = 4;
    localparam int c_DEF_CNT_BITS       = 16;
    localparam int c_DEF_SETTLE_CYCLES  = 16;
    localparam int c_DEF_WINDOW_CYCLES  = 1024;

    // Scan FSM states, explicitly sized and encoded
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        STORE   = 3'd3,
        DONE    = 3'd4
    } tero_state_e;

    // Larger of two integers, used to size the phase timer
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tero_edge_counter.sv
`default_nettype none
// ============================================================================
// Module      : tero_edge_counter
// Description : CNT_BITS-wide saturating counter with synchronous clear and
//               count enable. Clear has priority over counting.
// Revision    : 1.0 - initial release
// ============================================================================
module tero_edge_counter
    import tero_pkg::*;
#(
    parameter int CNT_BITS = c_DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                cnt_en,
    output logic [CNT_BITS-1:0] count
);

    localparam logic [CNT_BITS-1:0] c_MAX = '1;

    logic [CNT_BITS-1:0] r_count;

    // Count enabled events, stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (cnt_en && (r_count != c_MAX)) begin
            r_count <= r_count + CNT_BITS'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/tero_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tero_scan_ctrl
// Description : Scans all TEROs in challenge-offset pairs. Each TERO is
//               enabled, allowed to settle, then its oscillations are counted
//               over a fixed window. Within each pair, the first count
//               exceeding the second sets that pair's response bit.
//               Optional macro TERO_SCAN_DBG_EN adds cnt_dbg / cnt_dbg_valid
//               which expose each finished count during the STORE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tero_scan_ctrl
    import tero_pkg::*;
#(
    parameter int N_TERO_BITS    = c_DEF_N_TERO_BITS,
    parameter int CHALLENGE_BITS = c_DEF_CHALLENGE_BITS,
    parameter int CNT_BITS       = c_DEF_CNT_BITS,
    parameter int SETTLE_CYCLES  = c_DEF_SETTLE_CYCLES,
    parameter int WINDOW_CYCLES  = c_DEF_WINDOW_CYCLES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CHALLENGE_BITS-1:0]       challenge_in,
    input  logic                            tero_pulse,
    output logic [N_TERO_BITS-1:0]          tero_sel,
    output logic                            tero_en,
    output logic                            busy,
    output logic                            done,
    output logic [2**(N_TERO_BITS-1)-1:0]   response
`ifdef TERO_SCAN_DBG_EN
    ,
    output logic [CNT_BITS-1:0]             cnt_dbg,
    output logic                            cnt_dbg_valid
`endif
);

    localparam int c_N_TERO  = 2**N_TERO_BITS;
    localparam int c_N_PAIRS = c_N_TERO / 2;
    localparam int c_K_W     = (N_TERO_BITS > 1) ? N_TERO_BITS - 1 : 1;
    localparam int c_TMR_W   = $clog2(max2(SETTLE_CYCLES, WINDOW_CYCLES) + 1);

    localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_WINDOW_LAST = c_TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [c_K_W-1:0]   c_K_LAST      = c_K_W'(c_N_PAIRS - 1);

    tero_state_e            r_state;
    logic [c_TMR_W-1:0]     r_tmr;
    logic [c_K_W-1:0]       r_k;
    logic                   r_phase;    // 0 = first TERO of pair, 1 = second
    logic [N_TERO_BITS-1:0] r_chal;     // challenge already reduced mod N_TERO
    logic [CNT_BITS-1:0]    r_cnt_a;
    logic [c_N_PAIRS-1:0]   r_resp;

    logic [CNT_BITS-1:0]    w_count;
    logic [N_TERO_BITS-1:0] w_slot;
    logic                   w_clr;
    logic                   w_cnt_en;

    // Slot index 2k+phase; the addition below wraps modulo N_TERO
    assign w_slot   = N_TERO_BITS'({r_k, r_phase});
    assign w_clr    = (r_state == SETTLE);
    assign w_cnt_en = (r_state == MEASURE) && tero_pulse;

    tero_edge_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_clr),
        .cnt_en (w_cnt_en),
        .count  (w_count)
    );

    // Scan sequencing: settle, measure, store per TERO, then done
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_k     <= '0;
            r_phase <= 1'b0;
            r_chal  <= '0;
            r_cnt_a <= '0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_chal  <= N_TERO_BITS'(challenge_in);
                        r_k     <= '0;
                        r_phase <= 1'b0;
                        r_resp  <= '0;
                        r_tmr   <= '0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_tmr == c_SETTLE_LAST) begin
                        r_tmr   <= '0;
                        r_state <= MEASURE;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (r_tmr == c_WINDOW_LAST) begin
                        r_tmr   <= '0;
                        r_state <= STORE;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end
                STORE: begin
                    if (!r_phase) begin
                        r_cnt_a <= w_count;
                        r_phase <= 1'b1;
                        r_state <= SETTLE;
                    end else begin
                        // Strictly greater; a tie yields 0
                        r_resp[r_k] <= (r_cnt_a > w_count);
                        if (r_k == c_K_LAST) begin
                            r_state <= DONE;
                        end else begin
                            r_k     <= r_k + c_K_W'(1);
                            r_phase <= 1'b0;
                            r_state <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tero_sel = w_slot + r_chal;
    assign tero_en  = (r_state == SETTLE) || (r_state == MEASURE);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign response = r_resp;

`ifdef TERO_SCAN_DBG_EN
    // Expose the finished count only while it is being stored
    assign cnt_dbg_valid = (r_state == STORE);
    assign cnt_dbg       = cnt_dbg_valid ? w_count : '0;
`endif

endmodule
`default_nettype wire
